sram_bank_ctrl: RTL and testbench

- Parametrised controller for NB single-port synchronous SRAM macro banks that share one address.
- Accepts read/write requests over a valid/ready handshake and drives per-bank active-low chip/write enables.
- Returns the concatenated bank read data with 1-cycle latency, a response skid register and an out-of-range error flag.
- Sits between the GPU memory arbiter and the sram_gpu macro instances; EMA/RETN tie-offs stay at the instantiation site.

---
 rtl/sram_bank_ctrl_if.sv | 28 ++
 rtl/sram_bank_ctrl.sv | 133 +++++++++++++
 tb/tb_sram_bank_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bank_ctrl_if.sv
// Request/response bus between the GPU memory arbiter (master) and the
// SRAM bank controller (slave).
interface sram_bank_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 11,
    parameter int NB = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [NB-1:0]     req_mask;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [NB*DW-1:0]  rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sram_bank_ctrl.sv
// Controller for NB single-port synchronous SRAM banks sharing one address:
// combinational macro drive, 1-cycle read response with a skid hold register.
module sram_bank_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 11,
    parameter int NB    = 2,
    parameter int DEPTH = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    sram_bank_ctrl_if.slave  bus,
    output logic [NB-1:0]    sram_cen_n,
    output logic [NB-1:0]    sram_wen_n,
    output logic [AW-1:0]    sram_addr,
    output logic [DW-1:0]    sram_din,
    input  logic [NB*DW-1:0] sram_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e           state_q, state_d;
    logic [NB-1:0]    msk_q, msk_d;
    logic             err_q, err_d;
    logic [NB*DW-1:0] hold_data_q, hold_data_d;
    logic             hold_err_q, hold_err_d;

    logic             rsp_valid;
    logic             stall;
    logic             req_ready;
    logic             acc;
    logic             inr;
    logic [NB*DW-1:0] q_masked;
    logic [NB*DW-1:0] rsp_data;
    logic             rsp_err;

    // Handshake and macro drive: purely combinational from the request.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rsp_valid = (state_q != IDLE);
        stall     = rsp_valid && !bus.rsp_ready;
        req_ready = rst_n && !stall;
        acc       = bus.req_valid && req_ready;
        inr       = ({1'b0, bus.req_addr} < DEPTH_L);
        sram_cen_n = '1;
        sram_wen_n = '1;
        for (int b = 0; b < NB; b++) begin
            sram_cen_n[b] = !(acc && inr && bus.req_mask[b]);
            sram_wen_n[b] = !(bus.req_we && bus.req_mask[b]);
        end
    end

    assign sram_addr = bus.req_addr;
    assign sram_din  = bus.req_wdata;

    // Unselected lanes and out-of-range reads return zero.
    always_comb begin
        q_masked = '0;
        for (int b = 0; b < NB; b++) begin
            if (msk_q[b] && !err_q) begin
                q_masked[b*DW +: DW] = sram_q[b*DW +: DW];
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        rsp_err  = 1'b0;
        unique case (state_q)
            RESP: begin
                rsp_data = q_masked;
                rsp_err  = err_q;
            end
            HOLD: begin
                rsp_data = hold_data_q;
                rsp_err  = hold_err_q;
            end
            default: begin
                rsp_data = '0;
                rsp_err  = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_err   = rsp_err;

    // A stalled response is frozen in the hold register so later Q drift is harmless.
    always_comb begin
        state_d     = IDLE;
        msk_d       = msk_q;
        err_d       = err_q;
        hold_data_d = hold_data_q;
        hold_err_d  = hold_err_q;
        if (acc && !bus.req_we) begin
            state_d = RESP;
            msk_d   = bus.req_mask;
            err_d   = !inr;
        end else if (state_q == RESP && !bus.rsp_ready) begin
            state_d     = HOLD;
            hold_data_d = q_masked;
            hold_err_d  = err_q;
        end else if (state_q == HOLD && !bus.rsp_ready) begin
            state_d = HOLD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the hold register is reset too, so no stale response survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            msk_q       <= '0;
            err_q       <= 1'b0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            msk_q       <= msk_d;
            err_q       <= err_d;
            hold_data_q <= hold_data_d;
            hold_err_q  <= hold_err_d;
        end
    end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Randomised self-checking bench for sram_bank_ctrl against a response-queue
// reference model and a behavioural SRAM macro model.
module tb_sram_bank_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 11;
    localparam int NB    = 2;
    localparam int DEPTH = 1024;

    typedef struct {
        logic [NB*DW-1:0] data;
        logic             err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sram_bank_ctrl_if #(.DW(DW), .AW(AW), .NB(NB)) bus ();

    logic [NB-1:0]    sram_cen_n;
    logic [NB-1:0]    sram_wen_n;
    logic [AW-1:0]    sram_addr;
    logic [DW-1:0]    sram_din;
    logic [NB*DW-1:0] sram_q;

    sram_bank_ctrl #(.DW(DW), .AW(AW), .NB(NB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .sram_cen_n (sram_cen_n),
        .sram_wen_n (sram_wen_n),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_q     (sram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed(int b, int a);
        return 8'((a * 37 + b * 101 + 5) ^ (a >> 3));
    endfunction

    // Macro model: Q updates on a read edge, drifts to garbage when the bank is idle.
    logic [DW-1:0] mem    [NB][2**AW];
    logic [DW-1:0] q_lane [NB];
    logic          seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < 2**AW; a++)
                    mem[b][a] <= seed(b, a);
            seeded <= 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            if (!sram_cen_n[b]) begin
                if (!sram_wen_n[b]) mem[b][sram_addr] <= sram_din;
                else                q_lane[b] <= mem[b][sram_addr];
            end else begin
                q_lane[b] <= 8'($urandom);
            end
        end
    end

    assign sram_q = {q_lane[1], q_lane[0]};

    // Reference model state
    logic [DW-1:0] gm [NB][DEPTH];
    rsp_t          exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    logic             s_valid;
    logic [NB*DW-1:0] s_data;
    logic             s_err;
    logic [NB-1:0]    s_cen;
    logic             s_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic we, input logic [NB-1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
        logic          exp_ready;
        logic          acc;
        logic          inr;
        logic [NB-1:0] exp_cen;
        logic [NB-1:0] exp_wen;
        rsp_t          r;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_mask  = m;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        #1;
        exp_ready = !(exp_q.size() > 0 && !rr);
        acc       = v && exp_ready;
        inr       = (int'(a) < DEPTH);
        for (int b = 0; b < NB; b++) begin
            exp_cen[b] = !(acc && inr && m[b]);
            exp_wen[b] = !(we && m[b]);
        end
        check("req_ready", bus.req_ready, exp_ready);
        check("cen_n", sram_cen_n, exp_cen);
        check("wen_n", sram_wen_n, exp_wen);
        check("addr", sram_addr, a);
        check("din", sram_din, d);
        check("rsp_valid", bus.rsp_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("rsp_data", bus.rsp_data, exp_q[0].data);
            check("rsp_err", bus.rsp_err, exp_q[0].err);
        end
        s_valid = bus.rsp_valid;
        s_data  = bus.rsp_data;
        s_err   = bus.rsp_err;
        s_cen   = sram_cen_n;
        s_ready = bus.req_ready;
        @(posedge clk);
        if (exp_q.size() > 0 && rr) void'(exp_q.pop_front());
        if (acc) begin
            if (we) begin
                if (inr)
                    for (int b = 0; b < NB; b++)
                        if (m[b]) gm[b][a[9:0]] = d;
            end else begin
                r.data = '0;
                r.err  = !inr;
                if (inr)
                    for (int b = 0; b < NB; b++)
                        if (m[b]) r.data[b*DW +: DW] = gm[b][a[9:0]];
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'b0, '0, '0, '0, rr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int thru;
        logic [NB*DW-1:0] e11;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++)
                gm[b][a] = seed(b, a);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_mask  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_rsp_data", bus.rsp_data, '0);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_cen_n", sram_cen_n, 2'b11);
        check("rst_wen_n", sram_wen_n, 2'b11);
        rst_n = 1'b1;

        // Per-bank writes then full read
        cycle(1, 1, 2'b01, 11'h010, 8'hA5, 1);
        cycle(1, 1, 2'b10, 11'h010, 8'h3C, 1);
        cycle(1, 0, 2'b11, 11'h010, 8'h00, 1);
        idle(1);
        check("t1_valid", s_valid, 1'b1);
        check("t1_data", s_data, 16'h3CA5);
        check("t1_err", s_err, 1'b0);

        // Masked read
        cycle(1, 0, 2'b10, 11'h010, 8'h00, 1);
        check("t2_cen", s_cen, 2'b01);
        idle(1);
        check("t2_data", s_data, 16'h3C00);

        // Backpressure with skid hold
        e11 = {gm[1][17], gm[0][17]};
        cycle(1, 0, 2'b11, 11'h010, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 2'b11, 11'h011, 8'h00, 0);
            check("t3_hold_data", s_data, 16'h3CA5);
            check("t3_hold_ready", s_ready, 1'b0);
        end
        cycle(1, 0, 2'b11, 11'h011, 8'h00, 1);
        check("t3_release_ready", s_ready, 1'b1);
        idle(1);
        check("t3_next_data", s_data, e11);

        // Out of range
        cycle(1, 0, 2'b11, 11'h400, 8'h00, 1);
        check("t4_cen", s_cen, 2'b11);
        idle(1);
        check("t4_valid", s_valid, 1'b1);
        check("t4_err", s_err, 1'b1);
        check("t4_data", s_data, '0);
        cycle(1, 1, 2'b11, 11'h400, 8'hFF, 1);
        cycle(1, 0, 2'b11, 11'h000, 8'h00, 1);
        idle(1);
        check("t4_addr0", s_data, {seed(1, 0), seed(0, 0)});

        // Throughput
        thru = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 2'b11, 11'(32 + i), 8'h00, 1);
            if (i > 0 && s_valid) thru++;
        end
        idle(1);
        if (s_valid) thru++;
        check("t5_throughput", thru, 8);

        // Reset while holding a response
        cycle(1, 0, 2'b11, 11'h005, 8'h00, 1);
        idle(0);
        #2;
        check("t6_pre_valid", bus.rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", bus.rsp_valid, 1'b0);
        check("t6_async_ready", bus.req_ready, 1'b0);
        check("t6_async_data", bus.rsp_data, '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("t6_after_ready", s_ready, 1'b1);
        check("t6_after_valid", s_valid, 1'b0);
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 9))
                0:       a = 11'($urandom_range(1020, 1030));
                1:       a = 11'($urandom_range(2040, 2047));
                default: a = 11'($urandom_range(0, 15));
            endcase
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  2'($urandom), a, 8'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (3) idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
